acc_cmd_endpoint: RTL and testbench
===================================

# acc_cmd_endpoint

Accelerator-side endpoint of the manager command protocol. It receives execute-task commands on the cmdin stream, which the manager drives per accelerator via `cmdin_out_tdest`, decodes them, and starts the accelerator core with its task IDs and arguments. When the core completes, it returns a finish notification on the cmdout stream, which the manager receives on `cmdout_in_*`. One instance sits between the AXI-Stream interconnect and each accelerator core.

## Interface
Parameters:
- `MAX_ACCS`, 16: number of accelerators; sets the ID width `ID_W = $clog2(MAX_ACCS)`.
- `ACC_ID`, 0: this accelerator's index; driven on `cmdout_out_tid`.
- `MAX_ARGS`, 8: argument slots, range 1..255.

Ports:
- `aclk`, in, 1: clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `cmdin_in_tvalid`, in, 1: command stream valid (tdest already stripped by the interconnect).
- `cmdin_in_tready`, out, 1: command stream ready.
- `cmdin_in_tdata`, in, 64: command word.
- `cmdin_in_tlast`, in, 1: last word of the command.
- `cmdout_out_tvalid`, out, 1: finish stream valid.
- `cmdout_out_tready`, in, 1: finish stream ready.
- `cmdout_out_tid`, out, ID_W: constant `ACC_ID`.
- `cmdout_out_tdata`, out, 64: finish word.
- `core_start`, out, 1: one-cycle start pulse to the core.
- `core_task_id`, out, 64: task ID, held from start until the next header is accepted.
- `core_parent_id`, out, 64: parent task ID, held the same way.
- `core_num_args`, out, 8: N from the header.
- `core_args`, out, MAX_ARGS*64: argument i occupies bits `[64*i+63:64*i]`.
- `core_done`, in, 1: completion pulse from the core.
- `busy`, out, 1: high from header acceptance until the finish handshake completes.
- `err_bad_cmd`, out, 1: one-cycle pulse when a malformed command is dropped.

## Operation
Command format, one word per beat:
- Word 0 (header): `[7:0]` code, where 0x01 means execute; `[15:8]` N, the argument count; `[63:16]` ignored.
- Word 1: task ID.
- Word 2: parent task ID.
- Words 3..3+N-1: arguments.
- tlast must be set on the final word, which is word 2 when N=0.

Finish format: three words, no tlast.
- Word 0: `{48'h0, 8'h00, 8'h03}`.
- Word 1: task ID.
- Word 2: parent task ID.

FSM states: HDR, TID, PID, ARGS, DRAIN, START, RUN, FIN0, FIN1, FIN2.
- HDR: on handshake, clear `core_args` to 0 and latch N. Next state:
  - code≠0x01, or N>MAX_ARGS, or tlast=1: if tlast=1, pulse `err_bad_cmd` and stay in HDR; otherwise go to DRAIN.
  - otherwise go to TID.
- TID: latch the word. tlast=1 causes an error abort to HDR; otherwise go to PID.
- PID: latch the word.
  - N=0 and tlast=1: go to START.
  - N=0 and tlast=0: go to DRAIN.
  - N>0 and tlast=1: error abort to HDR.
  - N>0 and tlast=0: go to ARGS.
- ARGS: write arg[idx] and increment idx (counter width 8).
  - Word idx=N-1 with tlast: go to START.
  - Word idx=N-1 without tlast: go to DRAIN.
  - tlast on an earlier word: error abort to HDR.
- DRAIN: consume words until a tlast handshake, then pulse `err_bad_cmd` and go to HDR. The core is never started.
- START: assert `core_start` for one cycle, then go to RUN.
- RUN: wait for `core_done`, then go to FIN0. `core_done` is ignored in every other state.
- FIN0, FIN1, FIN2: present finish words 0, 1 and 2. Advance on each tvalid&tready. After FIN2 go to HDR.
- An error abort pulses `err_bad_cmd` in the cycle after the offending handshake.

## Timing
- Reset values: all outputs 0 except `cmdout_out_tid = ACC_ID`. The state is HDR. `cmdin_in_tready` is 0 during reset and rises to 1 in the first cycle after `rst` deasserts.
- `cmdin_in_tready` is a registered-state decode: 1 in HDR, TID, PID, ARGS and DRAIN; 0 otherwise. One word is accepted per cycle and there are no bubbles.
- `core_start` is high in the cycle after the last command word's handshake.
- `cmdout_out_tvalid` is high in the cycle after `core_done` is sampled in RUN. Data stays stable while tvalid=1 and tready=0. Back-to-back words follow when tready is held high.
- `cmdin_in_tready` rises in the cycle after the FIN2 handshake.
- Minimum command-to-command turnaround with `core_done` tied high is N+3 accept cycles, plus 1 START cycle, plus 1 RUN cycle, plus 3 FIN cycles.
- `rst` in any state returns to HDR next cycle:
  - Any in-flight finish is abandoned and tvalid drops.
  - Latched IDs are cleared.
  - No `err_bad_cmd` pulse is generated.

## Test plan
- Execute, N=2, task ID 0xA5, parent 0x11, args 0x100 and 0x200 with tlast on arg1: `core_start` occurs 1 cycle after the tlast handshake; `core_args` low 128 bits = {0x200, 0x100}. After `core_done`, the finish stream is 0x03, 0xA5, 0x11 with tid=`ACC_ID`.
- Execute, N=0, tlast on the parent word: start occurs; `core_args` is all zero; `core_num_args`=0.
- Malformed commands, each followed by a valid command that must still run:
  - header code 0x07 and 4-word packet: drained, one `err_bad_cmd` pulse, no start.
  - N=MAX_ARGS+1: same response.
  - N=3 with tlast on arg1: aborted with `err_bad_cmd`.
- Finish backpressure: hold `cmdout_out_tready` low for 5 cycles on each finish word. Each word stays stable; `cmdin_in_tready` stays 0 until the FIN2 handshake.
- Pulse `rst` during RUN, then pulse `core_done`: no finish is emitted; outputs return to their reset values; `cmdin_in_tready`=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/acc_cmd_endpoint.sv
// Accelerator-side command endpoint: decodes execute-task commands,
// starts the core, and returns a three-word finish notification.
module acc_cmd_endpoint #(
   parameter int MAX_ACCS = 16,
   parameter int ACC_ID   = 0,
   parameter int MAX_ARGS = 8,
   localparam int ID_W    = $clog2(MAX_ACCS)
) (
   input  logic                     aclk,
   input  logic                     rst,
   input  logic                     cmdin_in_tvalid,
   output logic                     cmdin_in_tready,
   input  logic [63:0]              cmdin_in_tdata,
   input  logic                     cmdin_in_tlast,
   output logic                     cmdout_out_tvalid,
   input  logic                     cmdout_out_tready,
   output logic [ID_W-1:0]          cmdout_out_tid,
   output logic [63:0]              cmdout_out_tdata,
   output logic                     core_start,
   output logic [63:0]              core_task_id,
   output logic [63:0]              core_parent_id,
   output logic [7:0]               core_num_args,
   output logic [MAX_ARGS*64-1:0]   core_args,
   input  logic                     core_done,
   output logic                     busy,
   output logic                     err_bad_cmd
);

   localparam logic [7:0] MAX_N   = 8'(MAX_ARGS);
   localparam logic [7:0] CODE_EX = 8'h01;

   typedef enum logic [3:0] {
      HDR, TID, PID, ARGS, DRAIN, START, RUN, FIN0, FIN1, FIN2
   } state_t;

   state_t state;
   state_t state_n;

   logic                          rdy;
   logic                          err;
   logic                          err_n;
   logic [63:0]                   task_id;
   logic [63:0]                   parent_id;
   logic [7:0]                    num_args;
   logic [7:0]                    idx;
   logic [MAX_ARGS-1:0][63:0]     args;

   logic       in_hs;
   logic       out_hs;
   logic [7:0] hdr_code;
   logic [7:0] hdr_n;
   logic       hdr_bad;
   logic       last_arg;

   assign in_hs    = cmdin_in_tvalid & rdy;
   assign out_hs   = cmdout_out_tvalid & cmdout_out_tready;
   assign hdr_code = cmdin_in_tdata[7:0];
   assign hdr_n    = cmdin_in_tdata[15:8];
   assign hdr_bad  = (hdr_code != CODE_EX) || (hdr_n > MAX_N);
   assign last_arg = (idx == num_args - 8'd1);

   always_comb begin
      state_n = state;
      err_n   = 1'b0;
      unique case (state)
         HDR: begin
            if (in_hs) begin
               if (hdr_bad || cmdin_in_tlast) begin
                  if (cmdin_in_tlast) err_n = 1'b1;
                  else                state_n = DRAIN;
               end else begin
                  state_n = TID;
               end
            end
         end
         TID: begin
            if (in_hs) begin
               if (cmdin_in_tlast) begin
                  err_n   = 1'b1;
                  state_n = HDR;
               end else begin
                  state_n = PID;
               end
            end
         end
         PID: begin
            if (in_hs) begin
               if (num_args == 8'd0) begin
                  state_n = cmdin_in_tlast ? START : DRAIN;
               end else if (cmdin_in_tlast) begin
                  err_n   = 1'b1;
                  state_n = HDR;
               end else begin
                  state_n = ARGS;
               end
            end
         end
         ARGS: begin
            if (in_hs) begin
               if (last_arg) begin
                  state_n = cmdin_in_tlast ? START : DRAIN;
               end else if (cmdin_in_tlast) begin
                  err_n   = 1'b1;
                  state_n = HDR;
               end
            end
         end
         DRAIN: begin
            if (in_hs && cmdin_in_tlast) begin
               err_n   = 1'b1;
               state_n = HDR;
            end
         end
         START: state_n = RUN;
         RUN: begin
            if (core_done) state_n = FIN0;
         end
         FIN0: begin
            if (out_hs) state_n = FIN1;
         end
         FIN1: begin
            if (out_hs) state_n = FIN2;
         end
         FIN2: begin
            if (out_hs) state_n = HDR;
         end
         default: state_n = HDR;
      endcase
   end

   // Ready is registered from the next state so it stays low during reset.
   always_ff @(posedge aclk) begin
      if (rst) begin
         state     <= HDR;
         rdy       <= 1'b0;
         err       <= 1'b0;
         task_id   <= '0;
         parent_id <= '0;
         num_args  <= '0;
         idx       <= '0;
         args      <= '0;
      end else begin
         state <= state_n;
         rdy   <= (state_n == HDR) || (state_n == TID) ||
                  (state_n == PID) || (state_n == ARGS) ||
                  (state_n == DRAIN);
         err   <= err_n;
         if (in_hs) begin
            unique case (state)
               HDR: begin
                  args     <= '0;
                  num_args <= hdr_n;
                  idx      <= '0;
               end
               TID: task_id <= cmdin_in_tdata;
               PID: parent_id <= cmdin_in_tdata;
               ARGS: begin
                  for (int i = 0; i < MAX_ARGS; i++) begin
                     if (idx == 8'(i)) args[i] <= cmdin_in_tdata;
                  end
                  idx <= idx + 8'd1;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      cmdout_out_tdata = '0;
      unique case (state)
         FIN0:    cmdout_out_tdata = {48'h0, 8'h00, 8'h03};
         FIN1:    cmdout_out_tdata = task_id;
         FIN2:    cmdout_out_tdata = parent_id;
         default: cmdout_out_tdata = '0;
      endcase
   end

   assign cmdin_in_tready   = rdy;
   assign cmdout_out_tvalid = (state == FIN0) || (state == FIN1) ||
                              (state == FIN2);
   assign cmdout_out_tid    = ID_W'(ACC_ID);
   assign core_start        = (state == START);
   assign core_task_id      = task_id;
   assign core_parent_id    = parent_id;
   assign core_num_args     = num_args;
   assign core_args         = args;
   assign busy              = (state != HDR);
   assign err_bad_cmd       = err;

endmodule

// File: tb/tb_acc_cmd_endpoint.sv
// Scoreboard bench for acc_cmd_endpoint: directed commands push expected
// start/finish/error events; a negedge monitor pops and compares them.
module tb_acc_cmd_endpoint;

   localparam int MAX_ACCS = 16;
   localparam int ACC_ID   = 5;
   localparam int MAX_ARGS = 8;
   localparam int ID_W     = $clog2(MAX_ACCS);
   localparam int AW       = MAX_ARGS * 64;

   logic            aclk = 1'b0;
   logic            rst;
   logic            cmdin_in_tvalid;
   logic            cmdin_in_tready;
   logic [63:0]     cmdin_in_tdata;
   logic            cmdin_in_tlast;
   logic            cmdout_out_tvalid;
   logic            cmdout_out_tready;
   logic [ID_W-1:0] cmdout_out_tid;
   logic [63:0]     cmdout_out_tdata;
   logic            core_start;
   logic [63:0]     core_task_id;
   logic [63:0]     core_parent_id;
   logic [7:0]      core_num_args;
   logic [AW-1:0]   core_args;
   logic            core_done;
   logic            busy;
   logic            err_bad_cmd;

   acc_cmd_endpoint #(
      .MAX_ACCS(MAX_ACCS), .ACC_ID(ACC_ID), .MAX_ARGS(MAX_ARGS)
   ) dut (
      .aclk(aclk), .rst(rst),
      .cmdin_in_tvalid(cmdin_in_tvalid), .cmdin_in_tready(cmdin_in_tready),
      .cmdin_in_tdata(cmdin_in_tdata), .cmdin_in_tlast(cmdin_in_tlast),
      .cmdout_out_tvalid(cmdout_out_tvalid),
      .cmdout_out_tready(cmdout_out_tready),
      .cmdout_out_tid(cmdout_out_tid), .cmdout_out_tdata(cmdout_out_tdata),
      .core_start(core_start), .core_task_id(core_task_id),
      .core_parent_id(core_parent_id), .core_num_args(core_num_args),
      .core_args(core_args), .core_done(core_done), .busy(busy),
      .err_bad_cmd(err_bad_cmd)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [63:0] tid;
      logic [63:0] pid;
      logic [7:0]  n;
      logic [AW-1:0] args;
   } start_t;

   start_t      exp_start[$];
   logic [63:0] exp_fin[$];
   int          err_pending = 0;
   logic [63:0] pkt[$];
   int          tests = 0;
   int          fails = 0;

   task automatic chk(input string name, input logic [AW-1:0] act,
                      input logic [AW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: consumes expected events as the DUT presents them.
   logic        stall_prev = 1'b0;
   logic [63:0] data_prev  = '0;
   always @(negedge aclk) begin
      if (rst !== 1'b0) begin
         stall_prev <= 1'b0;
      end else begin
         if (core_start) begin
            if (exp_start.size() == 0) begin
               chk("unexpected_start", 1, 0);
            end else begin
               start_t s;
               s = exp_start.pop_front();
               chk("start_task_id", core_task_id, s.tid);
               chk("start_parent_id", core_parent_id, s.pid);
               chk("start_num_args", core_num_args, s.n);
               chk("start_args", core_args, s.args);
            end
         end
         if (err_bad_cmd) begin
            if (err_pending == 0) chk("unexpected_err", 1, 0);
            else err_pending--;
         end
         if (cmdout_out_tvalid) begin
            chk("fin_tid", cmdout_out_tid, ID_W'(ACC_ID));
            if (stall_prev) chk("fin_stable", cmdout_out_tdata, data_prev);
            if (cmdout_out_tready) begin
               if (exp_fin.size() == 0) chk("unexpected_fin", 1, 0);
               else chk("fin_word", cmdout_out_tdata, exp_fin.pop_front());
            end
         end
         stall_prev <= cmdout_out_tvalid & ~cmdout_out_tready;
         data_prev  <= cmdout_out_tdata;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the last handshake.
   task automatic send_pkt();
      int n;
      n = pkt.size();
      for (int i = 0; i < n; i++) begin
         int cnt;
         cmdin_in_tvalid = 1'b1;
         cmdin_in_tdata  = pkt[i];
         cmdin_in_tlast  = (i == n - 1);
         cnt = 0;
         @(negedge aclk);
         while (!cmdin_in_tready && cnt < 50) begin
            @(negedge aclk);
            cnt++;
         end
         if (!cmdin_in_tready) begin
            chk("send_timeout", 0, 1);
            break;
         end
         @(posedge aclk);
         #1;
      end
      cmdin_in_tvalid = 1'b0;
      cmdin_in_tlast  = 1'b0;
      pkt.delete();
   endtask

   task automatic expect_cmd(input logic [63:0] tid, input logic [63:0] pid,
                             input logic [7:0] n, input logic [AW-1:0] a,
                             input bit fin);
      start_t s;
      s.tid = tid; s.pid = pid; s.n = n; s.args = a;
      exp_start.push_back(s);
      if (fin) begin
         exp_fin.push_back(64'h3);
         exp_fin.push_back(tid);
         exp_fin.push_back(pid);
      end
   endtask

   // START is the current cycle; move to RUN, then pulse done.
   task automatic start_then_done();
      chk("start_timing", core_start, 1);
      @(posedge aclk); #1;
      core_done = 1'b1;
      @(posedge aclk); #1;
      core_done = 1'b0;
   endtask

   task automatic wait_idle();
      int cnt;
      cnt = 0;
      @(negedge aclk);
      while (busy && cnt < 100) begin
         @(negedge aclk);
         cnt++;
      end
      chk("idle_timeout", busy, 0);
      @(posedge aclk); #1;
   endtask

   logic [AW-1:0] a;

   initial begin
      rst = 1'b1;
      cmdin_in_tvalid = 1'b0;
      cmdin_in_tdata = '0;
      cmdin_in_tlast = 1'b0;
      cmdout_out_tready = 1'b1;
      core_done = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_cmdin_tready", cmdin_in_tready, 0);
      chk("rst_tvalid", cmdout_out_tvalid, 0);
      chk("rst_tid", cmdout_out_tid, ID_W'(ACC_ID));
      chk("rst_busy", busy, 0);
      chk("rst_start", core_start, 0);
      chk("rst_err", err_bad_cmd, 0);
      chk("rst_task", core_task_id, 0);
      rst = 1'b0;
      chk("rst_release_ready_low", cmdin_in_tready, 0);
      @(posedge aclk); #1;
      chk("rst_release_ready_high", cmdin_in_tready, 1);

      // N=2 execute
      a = '0; a[63:0] = 64'h100; a[127:64] = 64'h200;
      expect_cmd(64'hA5, 64'h11, 8'd2, a, 1);
      pkt = '{64'h0201, 64'hA5, 64'h11, 64'h100, 64'h200};
      send_pkt();
      start_then_done();
      wait_idle();

      // N=0 execute
      expect_cmd(64'h22, 64'h33, 8'd0, '0, 1);
      pkt = '{64'h0001, 64'h22, 64'h33};
      send_pkt();
      start_then_done();
      wait_idle();

      // Bad code, drained; then good N=1 command
      err_pending++;
      pkt = '{64'h0007, 64'h1, 64'h2, 64'h3};
      send_pkt();
      a = '0; a[63:0] = 64'h777;
      expect_cmd(64'h44, 64'h55, 8'd1, a, 1);
      pkt = '{64'h0101, 64'h44, 64'h55, 64'h777};
      send_pkt();
      start_then_done();
      wait_idle();

      // N=MAX_ARGS+1, drained
      err_pending++;
      pkt = '{64'h0901, 64'h9, 64'hA};
      send_pkt();
      // N=3 with tlast on arg1, aborted
      err_pending++;
      pkt = '{64'h0301, 64'h1, 64'h2, 64'h10, 64'h20};
      send_pkt();
      // Header alone with tlast
      err_pending++;
      pkt = '{64'h0001};
      send_pkt();
      // N=0 with extra word, drained
      err_pending++;
      pkt = '{64'h0001, 64'h6, 64'h7, 64'h8};
      send_pkt();

      // N=MAX_ARGS, all slots filled
      a = '0;
      pkt = '{64'h0801, 64'h66, 64'h77};
      for (int i = 0; i < MAX_ARGS; i++) begin
         a[64*i +: 64] = 64'(i + 1) << 8;
         pkt.push_back(64'(i + 1) << 8);
      end
      expect_cmd(64'h66, 64'h77, 8'd8, a, 1);
      send_pkt();
      start_then_done();
      wait_idle();

      // Finish backpressure
      a = '0; a[63:0] = 64'hBEEF;
      expect_cmd(64'hC1, 64'hC2, 8'd1, a, 1);
      pkt = '{64'h0101, 64'hC1, 64'hC2, 64'hBEEF};
      cmdout_out_tready = 1'b0;
      send_pkt();
      start_then_done();
      for (int w = 0; w < 3; w++) begin
         repeat (5) begin
            @(posedge aclk); #1;
            chk("bp_cmdin_ready", cmdin_in_tready, 0);
            chk("bp_tvalid", cmdout_out_tvalid, 1);
         end
         cmdout_out_tready = 1'b1;
         @(posedge aclk); #1;
         cmdout_out_tready = 1'b0;
      end
      chk("bp_ready_after_fin2", cmdin_in_tready, 1);
      cmdout_out_tready = 1'b1;

      // Reset during RUN: no finish
      a = '0; a[63:0] = 64'h5;
      expect_cmd(64'hD1, 64'hD2, 8'd1, a, 0);
      pkt = '{64'h0101, 64'hD1, 64'hD2, 64'h5};
      send_pkt();
      chk("run_start", core_start, 1);
      @(posedge aclk); #1;
      rst = 1'b1;
      @(posedge aclk); #1;
      chk("rr_tvalid", cmdout_out_tvalid, 0);
      chk("rr_busy", busy, 0);
      chk("rr_task", core_task_id, 0);
      chk("rr_parent", core_parent_id, 0);
      chk("rr_nargs", core_num_args, 0);
      chk("rr_args", core_args, 0);
      chk("rr_ready", cmdin_in_tready, 0);
      rst = 1'b0;
      core_done = 1'b1;
      @(posedge aclk); #1;
      core_done = 1'b0;
      chk("rr_ready_after", cmdin_in_tready, 1);
      repeat (6) @(posedge aclk);
      #1;
      chk("rr_no_fin", cmdout_out_tvalid, 0);

      chk("left_starts", exp_start.size(), 0);
      chk("left_fins", exp_fin.size(), 0);
      chk("left_errs", err_pending, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
